digit_roi_binarizer: RTL and testbench
======================================

Name: digit_roi_binarizer

Overview:
- Upstream producer of the 28×28 1-bit digit image that the right-half display scaler reads through its buf_rd_x/buf_rd_y/buf_rd_data port.
- Consumes the raster grayscale camera stream and crops a 280×280 ROI.
- Bins the ROI into 10×10 blocks, counts dark pixels per block and thresholds each count to one bit.
- Stores the resulting 784 bits in a frame buffer with an asynchronous read port, so the scaler's registered address yields data in the same cycle.

Parameters:
ROI_X0, 116, ROI left edge in camera coordinates
ROI_Y0, 244, ROI top edge in camera coordinates
CNT_THRESH, 30, minimum dark pixels (of 100) per block for bit=1

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
capture_en  in  1  arms capture at next frame_start
frame_start  in  1  one-cycle pulse coincident with first pixel of a camera frame
pix_valid  in  1  pixel qualifier
pix_x  in  11  pixel column
pix_y  in  11  pixel row
pix_gray  in  8  luminance
dark_level  in  8  pixel is dark when pix_gray < dark_level
buf_rd_x  in  5  read column 0..27
buf_rd_y  in  5  read row 0..27
buf_rd_data  out  1  combinational read of display bank
busy  out  1  capture in progress
frame_done  out  1  one-cycle pulse when a new image becomes visible

Behaviour:
- Reset: busy=0, frame_done=0, both banks all-zero, display bank=0, accumulators=0, FSM=IDLE.
- FSM states: IDLE, CAPTURE, COMMIT.
  - IDLE→CAPTURE on frame_start && capture_en. Accumulators and block counters are cleared, and the frame_start pixel itself is processed.
  - CAPTURE→COMMIT when the pixel at ROI (279,279) has cleared stage 2.
  - COMMIT→IDLE after one cycle.
- frame_start in CAPTURE or COMMIT aborts the current image: no swap, no frame_done. The FSM restarts CAPTURE if capture_en=1, else goes to IDLE.
- ROI membership: ROI_X0 ≤ pix_x < ROI_X0+280 and ROI_Y0 ≤ pix_y < ROI_Y0+280. Non-ROI pixels and pix_valid=0 cycles are ignored. Input is raster order; gaps are allowed.
- No dividers. Stepping counters track the block position:
  - col_sub 0..9 and col_blk 0..27, both reset when rel_x==0.
  - row_sub 0..9 and row_blk 0..27, advanced after each ROI pixel with rel_x==279.
- Pipeline:
  - Stage 1 registers the dark bit, counters and the last-in-block flag.
  - Stage 2 performs acc[col_blk] += dark, using 28 accumulators of 7 bits.
  - On col_sub==9 && row_sub==9, stage 2 instead writes bit (acc+dark ≥ CNT_THRESH) to write bank [row_blk][col_blk] and clears that accumulator.
- Latency: last ROI pixel sampled at edge N → bit written at N+1 → COMMIT entered at N+2. COMMIT flips the display bank, and frame_done is high for exactly the cycle after N+2.
- busy=1 in CAPTURE and COMMIT.
- Read port:
  - buf_rd_data = display_bank[buf_rd_y][buf_rd_x], purely combinational.
  - buf_rd_x > 27 or buf_rd_y > 27 returns 0.
  - A swap is visible to reads from the cycle after the COMMIT edge; no partial image is ever visible.
- Asynchronous reset mid-capture: everything returns to reset values immediately.

Optional Feature:
- Macro ROI_DOUBLE_BUFFER_EN.
- Defined: two banks with write/display swap as above.
- Undefined:
  - A single bank is written in place and read directly, so tearing is acceptable.
  - COMMIT still pulses frame_done.
  - An aborted frame leaves partially updated bits.
  - Reset clears the single bank.

Decomposition:
- Package digit_img_pkg holds:
  - constants IMG_SIZE=28, SCALE=10, ROI_SIZE=280, ROI_X0, ROI_Y0;
  - the FSM state enum;
  - the block-index width (5) and accumulator width (7).
- One sub-module, bit_frame_buffer, with dual bank (or single bank under the macro):
  - synchronous 1-bit write by (row,col);
  - asynchronous read;
  - swap input.
- Binning, counters and FSM stay in the top module.

Test Plan:
- All ROI pixels gray=0, dark_level=128, capture_en=1 → frame_done once, 2 cycles after pixel (395,523); every read (0..27,0..27) returns 1.
- Threshold boundary: block (0,0) has exactly 30 dark pixels and block (0,1) has 29; CNT_THRESH=30 → read(0,0)=1, read(1,0)=0.
- Dark pixels only outside the ROI (pix_x=115, pix_y=243, pix_x=396) → all reads 0, frame_done still pulses.
- frame_start re-asserted at ROI row 150 → no frame_done, reads unchanged from the prior image. The next complete frame → frame_done and the new image.
- During capture, read (5,5) continuously → old value until the cycle after frame_done, then the new value (double buffer). Reads at (28,3) or (3,31) return 0.
- capture_en=0 at frame_start → busy stays 0, no frame_done. Assert rst_n low mid-capture → busy=0 and all reads 0.

Source files
------------

// File: rtl/digit_img_pkg.sv
// rtl/digit_img_pkg.sv - shared constants and FSM state type for the digit ROI binarizer (ROI_DOUBLE_BUFFER_EN)
package digit_img_pkg;

    localparam int IMG_SIZE = 28;
    localparam int SCALE    = 10;
    localparam int ROI_SIZE = IMG_SIZE * SCALE;
    localparam int ROI_X0   = 116;
    localparam int ROI_Y0   = 244;

    localparam int BLK_W = 5;
    localparam int ACC_W = 7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_COMMIT  = 2'd2
    } roi_state_e;

endpackage

// File: rtl/bit_frame_buffer.sv
// rtl/bit_frame_buffer.sv - 28x28 1-bit image store, dual bank with swap under ROI_DOUBLE_BUFFER_EN, single bank otherwise
module bit_frame_buffer
    import digit_img_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [BLK_W-1:0] wr_row,
    input  logic [BLK_W-1:0] wr_col,
    input  logic             wr_data,
    input  logic             swap,
    input  logic [BLK_W-1:0] rd_row,
    input  logic [BLK_W-1:0] rd_col,
    output logic             rd_data
);

    localparam logic [BLK_W-1:0] IMG_LIM = BLK_W'(IMG_SIZE);

    logic disp_bit;

`ifdef ROI_DOUBLE_BUFFER_EN
    logic [IMG_SIZE-1:0][IMG_SIZE-1:0] bank0;
    logic [IMG_SIZE-1:0][IMG_SIZE-1:0] bank1;
    logic                              disp_sel;

    // Writes land in the hidden bank; swap exchanges hidden and displayed banks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank0    <= '0;
            bank1    <= '0;
            disp_sel <= 1'b0;
        end else begin
            if (wr_en) begin
                if (disp_sel) begin
                    bank0[wr_row][wr_col] <= wr_data;
                end else begin
                    bank1[wr_row][wr_col] <= wr_data;
                end
            end
            if (swap) begin
                disp_sel <= ~disp_sel;
            end
        end
    end

    assign disp_bit = disp_sel ? bank1[rd_row][rd_col] : bank0[rd_row][rd_col];
`else
    logic [IMG_SIZE-1:0][IMG_SIZE-1:0] bank;
    logic                              unused_swap;

    // Single bank updated in place; readers may see a partially refreshed image.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank <= '0;
        end else if (wr_en) begin
            bank[wr_row][wr_col] <= wr_data;
        end
    end

    assign disp_bit    = bank[rd_row][rd_col];
    assign unused_swap = swap;
`endif

    assign rd_data = (rd_row < IMG_LIM && rd_col < IMG_LIM) ? disp_bit : 1'b0;

endmodule

// File: rtl/digit_roi_binarizer.sv
// rtl/digit_roi_binarizer.sv - crops a 280x280 ROI, bins 10x10 dark counts to a 28x28 bit image (ROI_DOUBLE_BUFFER_EN)
module digit_roi_binarizer #(
    parameter int ROI_X0     = digit_img_pkg::ROI_X0,
    parameter int ROI_Y0     = digit_img_pkg::ROI_Y0,
    parameter int CNT_THRESH = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        capture_en,
    input  logic        frame_start,
    input  logic        pix_valid,
    input  logic [10:0] pix_x,
    input  logic [10:0] pix_y,
    input  logic [7:0]  pix_gray,
    input  logic [7:0]  dark_level,
    input  logic [4:0]  buf_rd_x,
    input  logic [4:0]  buf_rd_y,
    output logic        buf_rd_data,
    output logic        busy,
    output logic        frame_done
);
    import digit_img_pkg::*;

    localparam logic [10:0]      X_LO     = 11'(ROI_X0);
    localparam logic [10:0]      X_HI     = 11'(ROI_X0 + ROI_SIZE);
    localparam logic [10:0]      Y_LO     = 11'(ROI_Y0);
    localparam logic [10:0]      Y_HI     = 11'(ROI_Y0 + ROI_SIZE);
    localparam logic [10:0]      REL_LAST = 11'(ROI_SIZE - 1);
    localparam logic [3:0]       SUB_LAST = 4'(SCALE - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(IMG_SIZE - 1);
    localparam logic [ACC_W:0]   THRESH   = (ACC_W + 1)'(CNT_THRESH);

    roi_state_e state, state_nxt;

    logic             start, in_roi, accept, row_end, pix_last;
    logic [10:0]      rel_x, rel_y;
    logic [3:0]       col_sub_q, row_sub_q, cur_col_sub, cur_row_sub;
    logic [BLK_W-1:0] col_blk_q, row_blk_q, cur_col_blk, cur_row_blk;

    logic             s1_valid, s1_dark, s1_blk_end, s1_last;
    logic [BLK_W-1:0] s1_col_blk, s1_row_blk;
    logic             s2_final;

    logic [ACC_W-1:0] acc [IMG_SIZE];
    logic [ACC_W:0]   acc_sum;
    logic             wr_en, wr_data, commit_ok;

    // A frame_start with capture armed (re)starts a capture from any state.
    assign start  = frame_start && capture_en;
    assign in_roi = (pix_x >= X_LO) && (pix_x < X_HI) && (pix_y >= Y_LO) && (pix_y < Y_HI);
    assign rel_x  = pix_x - X_LO;
    assign rel_y  = pix_y - Y_LO;
    assign accept = pix_valid && in_roi && (start || (state == ST_CAPTURE && !frame_start));

    assign row_end  = (rel_x == REL_LAST);
    assign pix_last = row_end && (rel_y == REL_LAST);

    assign cur_col_sub = (rel_x == 11'd0) ? 4'd0 : col_sub_q;
    assign cur_col_blk = (rel_x == 11'd0) ? '0 : col_blk_q;
    assign cur_row_sub = start ? 4'd0 : row_sub_q;
    assign cur_row_blk = start ? '0 : row_blk_q;

    // Block-position stepping counters: columns restart each ROI row, rows advance on the ROI row end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_sub_q <= '0;
            col_blk_q <= '0;
            row_sub_q <= '0;
            row_blk_q <= '0;
        end else begin
            if (start) begin
                row_sub_q <= '0;
                row_blk_q <= '0;
            end
            if (accept) begin
                if (cur_col_sub == SUB_LAST) begin
                    col_sub_q <= '0;
                    col_blk_q <= (cur_col_blk == BLK_LAST) ? '0 : cur_col_blk + 1'b1;
                end else begin
                    col_sub_q <= cur_col_sub + 4'd1;
                    col_blk_q <= cur_col_blk;
                end
                if (row_end) begin
                    if (cur_row_sub == SUB_LAST) begin
                        row_sub_q <= '0;
                        row_blk_q <= (cur_row_blk == BLK_LAST) ? '0 : cur_row_blk + 1'b1;
                    end else begin
                        row_sub_q <= cur_row_sub + 4'd1;
                        row_blk_q <= cur_row_blk;
                    end
                end
            end
        end
    end

    // Stage 1: register the dark decision with its block coordinates and end-of-block flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_dark    <= 1'b0;
            s1_blk_end <= 1'b0;
            s1_last    <= 1'b0;
            s1_col_blk <= '0;
            s1_row_blk <= '0;
        end else begin
            s1_valid   <= accept;
            s1_dark    <= pix_gray < dark_level;
            s1_blk_end <= (cur_col_sub == SUB_LAST) && (cur_row_sub == SUB_LAST);
            s1_last    <= pix_last;
            s1_col_blk <= cur_col_blk;
            s1_row_blk <= cur_row_blk;
        end
    end

    assign acc_sum = {1'b0, acc[s1_col_blk]} + (ACC_W + 1)'(s1_dark);
    assign wr_en   = s1_valid && s1_blk_end && !frame_start;
    assign wr_data = (acc_sum >= THRESH);

    // Stage 2: accumulate dark pixels per block column; the block's last pixel flushes and clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < IMG_SIZE; i++) begin
                acc[i] <= '0;
            end
            s2_final <= 1'b0;
        end else begin
            if (frame_start) begin
                for (int i = 0; i < IMG_SIZE; i++) begin
                    acc[i] <= '0;
                end
            end else if (s1_valid) begin
                if (s1_blk_end) begin
                    acc[s1_col_blk] <= '0;
                end else begin
                    acc[s1_col_blk] <= acc_sum[ACC_W-1:0];
                end
            end
            s2_final <= s1_valid && s1_last && !frame_start;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and outputs; a frame_start during COMMIT cancels the swap and frame_done.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        commit_ok = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                busy = 1'b1;
                if (frame_start) begin
                    state_nxt = capture_en ? ST_CAPTURE : ST_IDLE;
                end else if (s2_final) begin
                    state_nxt = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                busy = 1'b1;
                if (frame_start) begin
                    state_nxt = capture_en ? ST_CAPTURE : ST_IDLE;
                end else begin
                    commit_ok = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign frame_done = commit_ok;

    bit_frame_buffer u_frame_buffer (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_row  (s1_row_blk),
        .wr_col  (s1_col_blk),
        .wr_data (wr_data),
        .swap    (commit_ok),
        .rd_row  (buf_rd_y),
        .rd_col  (buf_rd_x),
        .rd_data (buf_rd_data)
    );

endmodule

// File: tb/tb_digit_roi_binarizer.sv
// tb/tb_digit_roi_binarizer.sv - directed self-checking bench for digit_roi_binarizer (ROI_DOUBLE_BUFFER_EN aware)
module tb_digit_roi_binarizer;

    localparam int X0 = 116;
    localparam int Y0 = 244;
    localparam int P_ALL = 0;
    localparam int P_OUT = 1;
    localparam int P_THR = 2;
    localparam int P_ABT = 3;
    localparam int P_NEW = 4;

    logic        clk = 1'b0;
    logic        rst_n, capture_en, frame_start, pix_valid;
    logic [10:0] pix_x, pix_y;
    logic [7:0]  pix_gray, dark_level;
    logic [4:0]  buf_rd_x, buf_rd_y;
    logic        buf_rd_data, busy, frame_done;

    digit_roi_binarizer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .capture_en  (capture_en),
        .frame_start (frame_start),
        .pix_valid   (pix_valid),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_gray    (pix_gray),
        .dark_level  (dark_level),
        .buf_rd_x    (buf_rd_x),
        .buf_rd_y    (buf_rd_y),
        .buf_rd_data (buf_rd_data),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] x;
        logic [4:0] y;
        logic       exp;
    } rd_vec_t;

    rd_vec_t ones_vecs [5];
    rd_vec_t thr_vecs  [8];

    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   busy_hi_cnt = 0;
    int   chg_cyc = 0;
    int   last_pix_cyc = 0;
    logic watch55 = 1'b0;
    logic img_exp [28][28];

    always @(posedge clk) cyc <= cyc + 1;

    // Edge-free observation of the pulse outputs and of the (5,5) read during a capture.
    always @(negedge clk) begin
        if (frame_done === 1'b1) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (busy === 1'b1) busy_hi_cnt <= busy_hi_cnt + 1;
        if (watch55 && chg_cyc == 0 && buf_rd_data === 1'b0) chg_cyc <= cyc;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    function automatic bit row_full(input int pat, input int ry);
        case (pat)
            P_ALL:   return (ry % 10) >= 7;
            P_THR:   return (ry < 10 && (ry % 10) >= 7) || (ry % 10) == 9;
            P_NEW:   return (ry / 10 == 1 && (ry % 10) >= 7) || (ry % 10) == 9;
            default: return (ry % 10) == 9;
        endcase
    endfunction

    function automatic bit is_dark(input int pat, input int rx, input int ry);
        case (pat)
            P_ALL, P_ABT: return 1'b1;
            P_THR:        return ry < 10 && rx < 30 && !(rx == 10 && ry == 7);
            P_NEW:        return ry / 10 == 1 && rx / 10 == 3;
            default:      return 1'b0;
        endcase
    endfunction

    task automatic drive(input logic v, input int x, input int y, input int g, input logic fs);
        pix_valid   = v;
        pix_x       = 11'(x);
        pix_y       = 11'(y);
        pix_gray    = 8'(g);
        frame_start = fs;
        @(posedge clk);
        #1;
        if (v && x == X0 + 279 && y == Y0 + 279) last_pix_cyc = cyc;
        frame_start = 1'b0;
        pix_valid   = 1'b0;
    endtask

    // Sparse raster frame: rows that hold no block-closing pixels carry only their ROI row-end pixel.
    task automatic send_frame(input int pat, input int stop_row);
        drive(1'b1, 0, 0, 255, 1'b1);
        drive(1'b1, 200, Y0 - 1, 0, 1'b0);
        for (int ry = 0; ry < 280; ry++) begin
            if (ry == stop_row) return;
            if (row_full(pat, ry)) begin
                drive(1'b0, X0 + 5, Y0 + ry, 0, 1'b0);
                drive(1'b1, X0 - 1, Y0 + ry, 0, 1'b0);
                for (int rx = 0; rx < 280; rx++)
                    drive(1'b1, X0 + rx, Y0 + ry, is_dark(pat, rx, ry) ? 0 : 255, 1'b0);
                drive(1'b1, X0 + 280, Y0 + ry, 0, 1'b0);
            end else begin
                drive(1'b1, X0 + 279, Y0 + ry, 255, 1'b0);
            end
        end
    endtask

    task automatic model_frame(input int pat, input int stop_row);
        int cnt [28][28];
        for (int by = 0; by < 28; by++)
            for (int bx = 0; bx < 28; bx++) cnt[by][bx] = 0;
        for (int ry = 0; ry < stop_row; ry++)
            if (row_full(pat, ry))
                for (int rx = 0; rx < 280; rx++)
                    if (is_dark(pat, rx, ry)) cnt[ry / 10][rx / 10]++;
`ifdef ROI_DOUBLE_BUFFER_EN
        if (stop_row < 280) return;
`endif
        for (int by = 0; by < 28; by++)
            if (10 * by + 9 < stop_row)
                for (int bx = 0; bx < 28; bx++) img_exp[by][bx] = (cnt[by][bx] >= 30);
    endtask

    task automatic compare_all(input string name);
        for (int y = 0; y < 28; y++) begin
            for (int x = 0; x < 28; x++) begin
                buf_rd_x = 5'(x);
                buf_rd_y = 5'(y);
                #1;
                check_bit($sformatf("%s x=%0d y=%0d", name, x, y), buf_rd_data, img_exp[y][x]);
            end
        end
    endtask

    task automatic drain();
        repeat (4) @(posedge clk);
        #1;
    endtask

    int base_done;
    int base_busy;

    initial begin
        ones_vecs[0] = '{5'd28, 5'd3,  1'b0};
        ones_vecs[1] = '{5'd3,  5'd31, 1'b0};
        ones_vecs[2] = '{5'd31, 5'd31, 1'b0};
        ones_vecs[3] = '{5'd27, 5'd0,  1'b1};
        ones_vecs[4] = '{5'd0,  5'd27, 1'b1};

        thr_vecs[0] = '{5'd0,  5'd0,  1'b1};
        thr_vecs[1] = '{5'd1,  5'd0,  1'b0};
        thr_vecs[2] = '{5'd2,  5'd0,  1'b1};
        thr_vecs[3] = '{5'd3,  5'd0,  1'b0};
        thr_vecs[4] = '{5'd0,  5'd1,  1'b0};
        thr_vecs[5] = '{5'd27, 5'd27, 1'b0};
        thr_vecs[6] = '{5'd28, 5'd3,  1'b0};
        thr_vecs[7] = '{5'd3,  5'd31, 1'b0};

        rst_n = 1'b0;
        capture_en = 1'b0;
        frame_start = 1'b0;
        pix_valid = 1'b0;
        pix_x = '0;
        pix_y = '0;
        pix_gray = 8'd255;
        dark_level = 8'd128;
        buf_rd_x = '0;
        buf_rd_y = '0;
        for (int y = 0; y < 28; y++)
            for (int x = 0; x < 28; x++) img_exp[y][x] = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_bit("reset_busy", busy, 1'b0);
        check_bit("reset_frame_done", frame_done, 1'b0);
        compare_all("reset_img");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        capture_en = 1'b1;

        // All-dark ROI: every block holds exactly 30 dark pixels.
        base_done = done_cnt;
        send_frame(P_ALL, 280);
        drain();
        check_int("all_dark_done_count", done_cnt - base_done, 1);
        check_int("all_dark_done_cycle", done_cyc, last_pix_cyc + 2);
        check_bit("all_dark_busy_after", busy, 1'b0);
        model_frame(P_ALL, 280);
        compare_all("all_dark_img");
        for (int i = 0; i < 5; i++) begin
            buf_rd_x = ones_vecs[i].x;
            buf_rd_y = ones_vecs[i].y;
            #1;
            check_bit($sformatf("ones_rd x=%0d y=%0d", ones_vecs[i].x, ones_vecs[i].y), buf_rd_data, ones_vecs[i].exp);
        end

        // Dark only outside the ROI, watching (5,5) fall from 1 to 0.
        buf_rd_x = 5'd5;
        buf_rd_y = 5'd5;
        #1;
        watch55 = 1'b1;
        base_done = done_cnt;
        send_frame(P_OUT, 280);
        drain();
        watch55 = 1'b0;
        check_int("outside_done_count", done_cnt - base_done, 1);
        check_int("outside_done_cycle", done_cyc, last_pix_cyc + 2);
`ifdef ROI_DOUBLE_BUFFER_EN
        check_int("swap_visible_cycle", chg_cyc, done_cyc + 1);
`else
        check_bit("inplace_update_before_done", (chg_cyc > 0) && (chg_cyc < done_cyc), 1'b1);
`endif
        model_frame(P_OUT, 280);
        compare_all("outside_img");

        // Threshold boundary: blocks (0,0)=30, (0,1)=29, (0,2)=30 dark pixels.
        base_done = done_cnt;
        send_frame(P_THR, 280);
        drain();
        check_int("thresh_done_count", done_cnt - base_done, 1);
        model_frame(P_THR, 280);
        compare_all("thresh_img");
        for (int i = 0; i < 8; i++) begin
            buf_rd_x = thr_vecs[i].x;
            buf_rd_y = thr_vecs[i].y;
            #1;
            check_bit($sformatf("thresh_rd x=%0d y=%0d", thr_vecs[i].x, thr_vecs[i].y), buf_rd_data, thr_vecs[i].exp);
        end

        // Abort at ROI row 150 by a new frame_start, which then runs to completion.
        base_done = done_cnt;
        send_frame(P_ABT, 150);
        drain();
        check_int("abort_no_done", done_cnt - base_done, 0);
        check_bit("abort_still_busy", busy, 1'b1);
        model_frame(P_ABT, 150);
        compare_all("abort_img");
        send_frame(P_NEW, 280);
        drain();
        check_int("restart_done_count", done_cnt - base_done, 1);
        check_int("restart_done_cycle", done_cyc, last_pix_cyc + 2);
        model_frame(P_NEW, 280);
        compare_all("restart_img");

        // capture_en low at frame_start: nothing is captured.
        capture_en = 1'b0;
        base_done = done_cnt;
        base_busy = busy_hi_cnt;
        send_frame(P_ALL, 30);
        drain();
        check_int("disarmed_busy_cycles", busy_hi_cnt - base_busy, 0);
        check_int("disarmed_no_done", done_cnt - base_done, 0);
        compare_all("disarmed_img");

        // Asynchronous reset in the middle of a capture.
        capture_en = 1'b1;
        send_frame(P_ALL, 40);
        check_bit("midcap_busy", busy, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check_bit("async_reset_busy", busy, 1'b0);
        check_bit("async_reset_frame_done", frame_done, 1'b0);
        for (int y = 0; y < 28; y++)
            for (int x = 0; x < 28; x++) img_exp[y][x] = 1'b0;
        compare_all("async_reset_img");
        @(negedge clk);
        rst_n = 1'b1;
        drain();
        check_bit("post_reset_busy", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
